// File: rtl/cla_serial_add.sv
// ---------------------------------------------------------------------------
// cla_serial_add -- byte-serial wide adder wrapped around a single cla_8.
//
// Two W-bit operands (W = 8*NBYTES) plus a carry-in are accepted over a
// valid/ready handshake. One byte per cycle is then pushed through cla_8,
// LSB first. The inter-byte carry lives only in a register. The W-bit sum
// and the carry-out are returned over a second valid/ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid && ready are both high. While valid is high and no transfer
// has happened yet, the payload is held stable. Ready never depends
// combinationally on valid.
//
// Parameters
//   NBYTES     operand width in bytes (>= 1)
//
// Optional feature
//   SIGNED_OVF_EN  when defined, adds output ovf. ovf is the two's-complement
//                  overflow flag, registered together with sum.
//
// Ports
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operand request
//   in_ready   out  1  high only while idle
//   a, b       in   W  operands
//   cin        in   1  carry-in
//   out_valid  out  1  result available
//   out_ready  in   1  consumer takes result
//   sum        out  W  registered sum
//   cout       out  1  registered carry-out of the MSB byte
//   ovf        out  1  signed overflow (SIGNED_OVF_EN only)
// ---------------------------------------------------------------------------

// 8-bit carry-lookahead adder. Each carry is expanded from the generate and
// propagate terms directly, so it does not ripple through the lower bits.
module cla_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
    always_comb begin
        logic term;
        logic pp;
        c    = '0;
        term = 1'b0;
        pp   = 1'b0;
        c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            term = g[i];
            pp   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (pp & g[j]);
                pp   = pp & p[j];
            end
            c[i+1] = term | (pp & cin);
        end
    end

    assign s    = p ^ c[7:0];
    assign cout = c[8];
endmodule

module cla_serial_add #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
`ifdef SIGNED_OVF_EN
    ,
    output logic                ovf
`endif
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  sum_sh;
    logic          carry_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          out_valid_q;

    logic [7:0]    byte_s;
    logic          byte_c;
    logic [W+7:0]  sum_wide;
    logic [W-1:0]  sum_shifted;
    logic          last_byte;
    logic          accept;
    logic          handoff;

    cla_8 u_cla (
        .a    (a_sh[7:0]),
        .b    (b_sh[7:0]),
        .cin  (carry_q),
        .s    (byte_s),
        .cout (byte_c)
    );

    // The new byte enters at the top and the partial sum moves down by one
    // byte. Building the shift from a wide vector keeps NBYTES=1 legal,
    // because no zero-width slice of sum_sh is ever needed.
    assign sum_wide    = {byte_s, sum_sh};
    assign sum_shifted = sum_wide[W+7:8];

    assign last_byte = (cnt_q == CW'(NBYTES - 1));
    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign handoff   = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_byte) state_d = DONE;
            DONE:    if (handoff)   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh        <= '0;
            b_sh        <= '0;
            sum_sh      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        sum_sh  <= '0;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 8;
                    b_sh    <= b_sh >> 8;
                    sum_sh  <= sum_shifted;
                    carry_q <= byte_c;
                    cnt_q   <= cnt_q + CW'(1);
                    // The last byte is being added on this edge. Publish the
                    // result directly from the adder outputs so it is visible
                    // exactly NBYTES edges after the accept edge.
                    if (last_byte) begin
                        sum_q       <= sum_shifted;
                        cout_q      <= byte_c;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (handoff) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIGNED_OVF_EN
    // The operand sign bits are latched at accept because the shift
    // registers lose them while the bytes are being processed. cin only
    // adds +1 and has no sign of its own.
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (accept) begin
                a_msb <= a[W-1];
                b_msb <= b[W-1];
            end
            if (state_q == RUN && last_byte) begin
                ovf_q <= (a_msb == b_msb) && (sum_shifted[W-1] != a_msb);
            end
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_add.sv
module tb_cla_serial_add;

    logic clk;
    logic rst_n;

    // NBYTES = 4 instance
    logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4;
    logic [31:0] a4, b4, sum4;
    // NBYTES = 1 instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
    logic [7:0]  a1, b1, sum1;
`ifdef SIGNED_OVF_EN
    logic        ovf4, ovf1;
`endif

    int n_vec;
    int n_bad;
    logic [32:0] exp_q[$];

    cla_serial_add #(.NBYTES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4)
`ifdef SIGNED_OVF_EN
        , .ovf(ovf4)
`endif
    );

    cla_serial_add #(.NBYTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef SIGNED_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic cur_in_ready(input int which);
        return (which == 4) ? in_ready4 : in_ready1;
    endfunction

    function automatic logic cur_out_valid(input int which);
        return (which == 4) ? out_valid4 : out_valid1;
    endfunction

    function automatic logic [31:0] cur_sum(input int which);
        return (which == 4) ? sum4 : {24'h0, sum1};
    endfunction

    function automatic logic cur_cout(input int which);
        return (which == 4) ? cout4 : cout1;
    endfunction

    function automatic logic cur_ovf(input int which);
`ifdef SIGNED_OVF_EN
        return (which == 4) ? ovf4 : ovf1;
`else
        return (which == 4) ? 1'b0 : 1'b0;
`endif
    endfunction

    task automatic set_in(input int which, input logic v, input logic [31:0] xa,
                          input logic [31:0] xb, input logic xc);
        if (which == 4) begin
            in_valid4 = v; a4 = xa; b4 = xb; cin4 = xc;
        end else begin
            in_valid1 = v; a1 = xa[7:0]; b1 = xb[7:0]; cin1 = xc;
        end
    endtask

    task automatic set_out_ready(input int which, input logic v);
        if (which == 4) out_ready4 = v;
        else            out_ready1 = v;
    endtask

    // Full transaction: request, wait for the result, hold out_ready low for
    // 'stall' cycles, hand off. lat counts edges from accept to out_valid.
    task automatic run_op(input int which, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xc, input int stall,
                          output logic [31:0] rs, output logic rc, output logic ro,
                          output int lat);
        int n;
        @(negedge clk);
        set_in(which, 1'b1, xa, xb, xc);
        n = 0;
        while (!cur_in_ready(which) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 64'(n), 64'(0));
        @(negedge clk);               // accept edge has passed
        set_in(which, 1'b0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!cur_out_valid(which) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rs = cur_sum(which);
        rc = cur_cout(which);
        ro = cur_ovf(which);
        repeat (stall) @(negedge clk);
        set_out_ready(which, 1'b1);
        @(negedge clk);
        set_out_ready(which, 1'b0);
        check("out_valid_drop", 64'(cur_out_valid(which)), 64'(0));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          stall;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] rs;
        logic        rc;
        logic        ro;
        int          lat;
        logic [32:0] exp;
        logic [31:0] ra, rb;
        logic        rcin;
        int          cnt_bad;

        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[2]  = '{32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0, 1'b0, 0};
        vecs[3]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 2};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 0};
        vecs[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 0};
        vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 3};
        vecs[7]  = '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 0};
        vecs[8]  = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0, 1};
        vecs[9]  = '{32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEF0, 1'b0, 1'b0, 0};
        vecs[10] = '{32'h00000005, 32'h00000007, 1'b0, 32'h0000000C, 1'b0, 1'b0, 0};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
        set_in(1, 1'b0, 32'h0, 32'h0, 1'b0);
        out_ready4 = 1'b0;
        out_ready1 = 1'b0;
        #1;
        check("rst_in_ready",  64'(in_ready4),  64'(1));
        check("rst_out_valid", 64'(out_valid4), 64'(0));
        check("rst_sum",       64'(sum4),       64'(0));
        check("rst_cout",      64'(cout4),      64'(0));
        check("rst_out_valid1", 64'(out_valid1), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 0; i < 11; i++) begin
            run_op(4, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, rs, rc, ro, lat);
            check($sformatf("vec%0d_sum", i),  64'(rs),  64'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 64'(rc),  64'(vecs[i].cout));
            check($sformatf("vec%0d_lat", i),  64'(lat), 64'(4));
`ifdef SIGNED_OVF_EN
            check($sformatf("vec%0d_ovf", i),  64'(ro),  64'(vecs[i].ovf));
`endif
        end

        // ---------------- hold in DONE, in_valid pulsed ----------------
        @(negedge clk);
        set_in(4, 1'b1, 32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("hold_lat", 64'(lat), 64'(4));
        for (int i = 0; i < 5; i++) begin
            set_in(4, 1'b1, 32'hAAAAAAAA, 32'h22222222, 1'b1);
            @(negedge clk);
            check($sformatf("hold%0d_out_valid", i), 64'(out_valid4), 64'(1));
            check($sformatf("hold%0d_in_ready", i),  64'(in_ready4),  64'(0));
            check($sformatf("hold%0d_sum", i),       64'(sum4),       64'(32'h33333333));
            check($sformatf("hold%0d_cout", i),      64'(cout4),      64'(0));
        end
        set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
        out_ready4 = 1'b1;
        @(negedge clk);
        out_ready4 = 1'b0;
        check("hold_release_out_valid", 64'(out_valid4), 64'(0));
        check("hold_release_in_ready",  64'(in_ready4),  64'(1));
        repeat (3) @(negedge clk);
        check("hold_no_extra_op", 64'(in_ready4), 64'(1));
        run_op(4, 32'hAAAAAAAA, 32'h22222222, 1'b0, 0, rs, rc, ro, lat);
        check("after_hold_sum", 64'(rs), 64'(32'hCCCCCCCC));

        // ---------------- reset during RUN ----------------
        @(negedge clk);
        set_in(4, 1'b1, 32'h01020304, 32'h10203040, 1'b1);
        @(negedge clk);               // accept edge passed, counter = 0
        set_in(4, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);    // counter = 2
        check("midrun_in_ready", 64'(in_ready4), 64'(0));
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid4), 64'(0));
        check("midrst_sum",       64'(sum4),       64'(0));
        check("midrst_cout",      64'(cout4),      64'(0));
        check("midrst_in_ready",  64'(in_ready4),  64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        cnt_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) cnt_bad++;
        end
        check("postrst_idle_cycles", 64'(cnt_bad), 64'(0));
        run_op(4, 32'd5, 32'd7, 1'b0, 0, rs, rc, ro, lat);
        check("postrst_sum",  64'(rs),  64'(12));
        check("postrst_cout", 64'(rc),  64'(0));
        check("postrst_lat",  64'(lat), 64'(4));

        // ---------------- NBYTES=1 directed ----------------
        run_op(1, 32'hFF, 32'h01, 1'b0, 0, rs, rc, ro, lat);
        check("b1_carry_sum",  64'(rs),  64'(0));
        check("b1_carry_cout", 64'(rc),  64'(1));
        check("b1_lat",        64'(lat), 64'(1));
`ifdef SIGNED_OVF_EN
        check("b1_ovf",        64'(ro),  64'(0));
        run_op(1, 32'h7F, 32'h01, 1'b0, 0, rs, rc, ro, lat);
        check("b1_ovf_pos",    64'(ro),  64'(1));
`endif

        // ---------------- random, both widths ----------------
        for (int i = 0; i < 500; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rcin = 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, ra} + {1'b0, rb} + 33'(rcin));
            run_op(4, ra, rb, rcin, $urandom_range(0, 3), rs, rc, ro, lat);
            exp = exp_q.pop_front();
            check($sformatf("rnd4_%0d", i), 64'({rc, rs}), 64'(exp));
            check($sformatf("rnd4_lat%0d", i), 64'(lat), 64'(4));
        end
        for (int i = 0; i < 500; i++) begin
            ra   = 32'($urandom_range(0, 255));
            rb   = 32'($urandom_range(0, 255));
            rcin = 1'($urandom_range(0, 1));
            exp_q.push_back(33'(ra[7:0]) + 33'(rb[7:0]) + 33'(rcin));
            run_op(1, ra, rb, rcin, $urandom_range(0, 3), rs, rc, ro, lat);
            exp = exp_q.pop_front();
            check($sformatf("rnd1_%0d", i), 64'({rc, rs[7:0]}), 64'(exp));
            check($sformatf("rnd1_lat%0d", i), 64'(lat), 64'(1));
        end
        check("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
